seq_detect_fsm: RTL and testbench
=================================

SEQ_DETECT_FSM -- requirements
Module: seq_detect_fsm

Interface
REQ-001 The block SHALL have parameter SYM_W, default 2: symbol width in bits.
REQ-002 The block SHALL have parameter SEQ_LEN, default 3: pattern length in symbols, legal range 2..8.
REQ-003 The block SHALL have parameter CNT_W, default 8: match-counter width.
REQ-004 Port clk_i  in  1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_ni  in  1: reset, asynchronous, active-low.
REQ-006 Port valid_i  in  1: control_signal_i carries a symbol this cycle.
REQ-007 Port control_signal_i  in  SYM_W: input symbol.
REQ-008 Port load_i  in  1: latch pattern_i and re-arm the detector.
REQ-009 Port pattern_i  in  SEQ_LEN*SYM_W: pattern; symbol k is bits [k*SYM_W +: SYM_W]; symbol 0 is expected first.
REQ-010 Port overlap_i  in  1: 1 = overlapping detection, 0 = non-overlapping; sampled on every accepted symbol.
REQ-011 Port clr_cnt_i  in  1: synchronous clear of match counter.
REQ-012 Port result_o  out  2: FSM state (0 UNARMED, 1 FILL, 2 HUNT; 3 never driven).
REQ-013 Port match_o  out  1: registered one-cycle match pulse.
REQ-014 Port match_cnt_o  out  CNT_W: saturating match count.
REQ-015 Port cnt_sat_o  out  1: high while match_cnt_o equals 2^CNT_W-1.

Function
REQ-016 The block SHALL keep a history register of the last SEQ_LEN accepted symbols plus a fill counter 0..SEQ_LEN.
REQ-017 A symbol SHALL be accepted on a rising edge with valid_i=1, load_i=0 and state != UNARMED; when valid_i=0, history, fill count and state SHALL hold.
REQ-018 UNARMED: symbols ignored; load_i=1 -> FILL.
REQ-019 FILL: each accepted symbol shifts into history and increments fill count; the edge that makes fill count reach SEQ_LEN SHALL evaluate a match and move to HUNT.
REQ-020 HUNT: each accepted symbol shifts into history and SHALL evaluate a match.
REQ-021 A match SHALL be declared when the last SEQ_LEN accepted symbols, oldest first, equal pattern symbols 0..SEQ_LEN-1.
REQ-022 On a match, match_o SHALL be 1 for exactly the clock cycle following the sampling edge, else 0; latency from completing symbol to match_o is 1 cycle.
REQ-023 On a match with overlap_i=1, state SHALL be HUNT and history retained.
REQ-024 On a match with overlap_i=0, history and fill count SHALL clear and state SHALL become FILL.
REQ-025 load_i=1 in any state SHALL latch pattern_i, clear history and fill count, and enter FILL; a symbol presented the same cycle SHALL be discarded and no match evaluated.
REQ-026 match_cnt_o SHALL increment by 1 on the edge that declares a match and SHALL saturate at 2^CNT_W-1 without wrap.
REQ-027 clr_cnt_i=1 SHALL set match_cnt_o to 0; on a simultaneous match, clear SHALL win and match_o SHALL still pulse.
REQ-028 load_i SHALL NOT affect match_cnt_o.
REQ-029 Back-to-back valid symbols on every cycle SHALL be accepted without stall.

Reset
REQ-030 While rst_ni=0, regardless of clk_i: result_o=0 (UNARMED), match_o=0, match_cnt_o=0, cnt_sat_o=0, pattern, history and fill count all 0.
REQ-031 Reset asserted mid-sequence SHALL discard partial history; after release, the block SHALL require load_i before detecting.

Verification
REQ-032 Reset then symbols with no load -> result_o=0, match_o never 1, match_cnt_o=0.
REQ-033 Defaults, load pattern_i=6'b10_00_01 (sequence 1,0,2), stream 1,0,2 -> match_o=1 one cycle after the symbol-2 edge, match_cnt_o=1, result_o=2.
REQ-034 Pattern 0,0,0, overlap_i=1, stream 0,0,0,0 -> two match pulses on consecutive cycles, match_cnt_o=2; with overlap_i=0 -> one pulse, match_cnt_o=1, result_o=1 after the match.
REQ-035 Pattern 1,0,2, stream 1,0 then valid_i=0 for 3 cycles then 2 -> match declared (gaps hold); stream 1,0, load_i pulse, 2 -> no match, result_o=1.
REQ-036 CNT_W=2, 4 matches -> match_cnt_o=3, cnt_sat_o=1; clr_cnt_i with a 5th match -> match_o=1, match_cnt_o=0, cnt_sat_o=0.
REQ-037 rst_ni asserted between clock edges during FILL -> outputs reach reset values immediately, with no clk_i edge required.

Source files
------------

// File: rtl/seq_detect_fsm.sv
// Symbol-sequence detector: matches the last SEQ_LEN accepted symbols against a
// loaded pattern, with overlapping/non-overlapping modes and a saturating hit count.

module seq_sym_cmp #(
  parameter int SYM_W = 2
) (
  input  logic [SYM_W-1:0] sym,
  input  logic [SYM_W-1:0] pat,
  output logic             eq
);
  assign eq = (sym == pat);
endmodule

module seq_detect_fsm #(
  parameter int SYM_W   = 2,
  parameter int SEQ_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  input  logic [SYM_W-1:0]         control_signal_i,
  input  logic                     load_i,
  input  logic [SEQ_LEN*SYM_W-1:0] pattern_i,
  input  logic                     overlap_i,
  input  logic                     clr_cnt_i,
  output logic [1:0]               result_o,
  output logic                     match_o,
  output logic [CNT_W-1:0]         match_cnt_o,
  output logic                     cnt_sat_o
);
  typedef enum logic [1:0] {UNARMED = 2'd0, FILL = 2'd1, HUNT = 2'd2} state_t;
  localparam int FC_W = $clog2(SEQ_LEN + 1);

  state_t                          state;
  logic [SEQ_LEN-1:0][SYM_W-1:0]   pat, hist, hist_nxt;
  logic [FC_W-1:0]                 fill;
  logic [SEQ_LEN-1:0]              sym_eq;
  logic                            accept, full_nxt, hit;

  // hist[0] is the oldest symbol; new symbols enter at the top index
  assign hist_nxt = {control_signal_i, hist[SEQ_LEN-1:1]};
  assign accept   = valid_i && !load_i && (state != UNARMED);
  assign full_nxt = (state == HUNT) || (fill == FC_W'(SEQ_LEN - 1));

  for (genvar k = 0; k < SEQ_LEN; k++) begin : g_cmp
    seq_sym_cmp #(.SYM_W(SYM_W)) u_cmp (
      .sym (hist_nxt[k]),
      .pat (pat[k]),
      .eq  (sym_eq[k])
    );
  end

  assign hit       = accept && full_nxt && (&sym_eq);
  assign result_o  = state;
  assign cnt_sat_o = &match_cnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= UNARMED;
      pat         <= '0;
      hist        <= '0;
      fill        <= '0;
      match_o     <= 1'b0;
      match_cnt_o <= '0;
    end else begin
      match_o <= hit;
      // clear beats a simultaneous increment
      if (clr_cnt_i)                      match_cnt_o <= '0;
      else if (hit && !(&match_cnt_o))    match_cnt_o <= match_cnt_o + 1'b1;

      if (load_i) begin
        pat   <= pattern_i;
        hist  <= '0;
        fill  <= '0;
        state <= FILL;
      end else if (accept) begin
        if (hit && !overlap_i) begin
          hist  <= '0;
          fill  <= '0;
          state <= FILL;
        end else begin
          hist <= hist_nxt;
          if (state == FILL) fill  <= fill + 1'b1;
          if (full_nxt)      state <= HUNT;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: directed scenarios plus a random run against a
// queue-based model of the last accepted symbols.

module tb_seq_detect_fsm;
  localparam int L = 3;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       valid_i, load_i, overlap_i, clr_cnt_i;
  logic [1:0] control_signal_i;
  logic [5:0] pattern_i;
  logic [1:0] result_o, result2;
  logic       match_o, match2, cnt_sat_o, sat2;
  logic [7:0] match_cnt_o;
  logic [1:0] cnt2;

  int pass_cnt = 0, chk_cnt = 0;

  // model state
  bit       armed, hunting, exp_match;
  int       q[$];
  logic [5:0] m_pat;
  int       c8, c2;

  always #5 clk_i = ~clk_i;

  seq_detect_fsm dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .control_signal_i(control_signal_i),
    .load_i(load_i), .pattern_i(pattern_i), .overlap_i(overlap_i), .clr_cnt_i(clr_cnt_i),
    .result_o(result_o), .match_o(match_o), .match_cnt_o(match_cnt_o), .cnt_sat_o(cnt_sat_o)
  );

  seq_detect_fsm #(.CNT_W(2)) dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .control_signal_i(control_signal_i),
    .load_i(load_i), .pattern_i(pattern_i), .overlap_i(overlap_i), .clr_cnt_i(clr_cnt_i),
    .result_o(result2), .match_o(match2), .match_cnt_o(cnt2), .cnt_sat_o(sat2)
  );

  function automatic int exp_res();
    return !armed ? 0 : (hunting ? 2 : 1);
  endfunction

  task automatic model_reset();
    armed = 0; hunting = 0; exp_match = 0; q.delete(); m_pat = '0; c8 = 0; c2 = 0;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, settle 1ns.
  task automatic step(input logic v, input logic [1:0] s, input logic ld,
                      input logic [5:0] pat, input logic ov, input logic clr);
    bit eq;
    valid_i = v; control_signal_i = s; load_i = ld; pattern_i = pat;
    overlap_i = ov; clr_cnt_i = clr;
    @(posedge clk_i);
    exp_match = 0;
    if (ld) begin
      armed = 1; hunting = 0; q.delete(); m_pat = pat;
    end else if (v && armed) begin
      q.push_back(int'(s));
      if (q.size() > L) void'(q.pop_front());
      if (q.size() == L) begin
        hunting = 1;
        eq = 1;
        for (int k = 0; k < L; k++) if (q[k] != int'(m_pat[k*2 +: 2])) eq = 0;
        if (eq) begin
          exp_match = 1;
          if (!ov) begin q.delete(); hunting = 0; end
        end
      end
    end
    if (clr) begin c8 = 0; c2 = 0; end
    else if (exp_match) begin
      if (c8 < 255) c8++;
      if (c2 < 3)   c2++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 0; valid_i = 0; control_signal_i = 0; load_i = 0; pattern_i = 0;
    overlap_i = 0; clr_cnt_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk_cnt++; if (result_o !== 2'd0) $display("FAIL reset_result got=%0d exp=0", result_o); else pass_cnt++;
    chk_cnt++; if (match_o !== 1'b0) $display("FAIL reset_match got=%0b exp=0", match_o); else pass_cnt++;
    chk_cnt++; if (match_cnt_o !== 8'd0) $display("FAIL reset_cnt got=%0d exp=0", match_cnt_o); else pass_cnt++;
    chk_cnt++; if (cnt_sat_o !== 1'b0 || sat2 !== 1'b0) $display("FAIL reset_sat got=%0b/%0b exp=0", cnt_sat_o, sat2); else pass_cnt++;
    rst_ni = 1;
  endtask

  task automatic test_no_load();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 6'b10_00_01, 1'b1, 1'b0);
      chk_cnt++;
      if (result_o !== 2'd0 || match_o !== 1'b0 || match_cnt_o !== 8'd0)
        $display("FAIL no_load cyc=%0d got res=%0d m=%0b c=%0d exp res=0 m=0 c=0", i, result_o, match_o, match_cnt_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic();
    step(1'b0, 2'd0, 1'b1, 6'b10_00_01, 1'b1, 1'b0);
    chk_cnt++; if (result_o !== 2'd1) $display("FAIL basic_load_res got=%0d exp=1", result_o); else pass_cnt++;
    step(1'b1, 2'd1, 1'b0, 6'd0, 1'b1, 1'b0);
    step(1'b1, 2'd0, 1'b0, 6'd0, 1'b1, 1'b0);
    chk_cnt++; if (match_o !== 1'b0) $display("FAIL basic_early_match got=%0b exp=0", match_o); else pass_cnt++;
    step(1'b1, 2'd2, 1'b0, 6'd0, 1'b1, 1'b0);
    chk_cnt++;
    if (match_o !== 1'b1 || match_cnt_o !== 8'd1 || result_o !== 2'd2)
      $display("FAIL basic_match got m=%0b c=%0d r=%0d exp m=1 c=1 r=2", match_o, match_cnt_o, result_o);
    else pass_cnt++;
    step(1'b0, 2'd0, 1'b0, 6'd0, 1'b1, 1'b0);
    chk_cnt++; if (match_o !== 1'b0) $display("FAIL basic_pulse_width got=%0b exp=0", match_o); else pass_cnt++;
  endtask

  task automatic test_overlap(input logic ov);
    int pulses, exp_pulses;
    pulses = 0;
    step(1'b0, 2'd0, 1'b1, 6'b00_00_00, ov, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd0, 1'b0, 6'd0, ov, 1'b0);
      pulses += int'(match_o);
      chk_cnt++;
      if (match_o !== exp_match || result_o !== 2'(exp_res()))
        $display("FAIL overlap%0b cyc=%0d got m=%0b r=%0d exp m=%0b r=%0d", ov, i, match_o, result_o, exp_match, exp_res());
      else pass_cnt++;
    end
    exp_pulses = ov ? 2 : 1;
    chk_cnt++;
    if (pulses != exp_pulses || match_cnt_o !== 8'(exp_pulses) || result_o !== (ov ? 2'd2 : 2'd1))
      $display("FAIL overlap%0b_total got p=%0d c=%0d r=%0d exp p=%0d c=%0d r=%0d",
               ov, pulses, match_cnt_o, result_o, exp_pulses, exp_pulses, ov ? 2 : 1);
    else pass_cnt++;
  endtask

  task automatic test_gap_and_load();
    step(1'b0, 2'd0, 1'b1, 6'b10_00_01, 1'b0, 1'b1);
    step(1'b1, 2'd1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd2, 1'b0, 6'd0, 1'b0, 1'b0);
    chk_cnt++; if (match_o !== 1'b0 || result_o !== 2'd1) $display("FAIL gap_hold got m=%0b r=%0d exp m=0 r=1", match_o, result_o); else pass_cnt++;
    step(1'b1, 2'd2, 1'b0, 6'd0, 1'b0, 1'b0);
    chk_cnt++; if (match_o !== 1'b1 || match_cnt_o !== 8'd1) $display("FAIL gap_match got m=%0b c=%0d exp m=1 c=1", match_o, match_cnt_o); else pass_cnt++;
    step(1'b1, 2'd1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b1, 6'b10_00_01, 1'b0, 1'b0);
    chk_cnt++; if (match_o !== 1'b0) $display("FAIL load_discard got m=%0b exp=0", match_o); else pass_cnt++;
    step(1'b1, 2'd2, 1'b0, 6'd0, 1'b0, 1'b0);
    chk_cnt++;
    if (match_o !== 1'b0 || result_o !== 2'd1 || match_cnt_o !== 8'd1)
      $display("FAIL load_rearm got m=%0b r=%0d c=%0d exp m=0 r=1 c=1", match_o, result_o, match_cnt_o);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    step(1'b0, 2'd0, 1'b1, 6'b00_00_00, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 2'd0, 1'b0, 6'd0, 1'b1, 1'b0);
    chk_cnt++;
    if (cnt2 !== 2'd3 || sat2 !== 1'b1 || match_cnt_o !== 8'd4 || cnt_sat_o !== 1'b0)
      $display("FAIL sat got c2=%0d s2=%0b c8=%0d s8=%0b exp c2=3 s2=1 c8=4 s8=0", cnt2, sat2, match_cnt_o, cnt_sat_o);
    else pass_cnt++;
    step(1'b1, 2'd0, 1'b0, 6'd0, 1'b1, 1'b1);
    chk_cnt++;
    if (match2 !== 1'b1 || cnt2 !== 2'd0 || sat2 !== 1'b0 || match_cnt_o !== 8'd0)
      $display("FAIL clr_wins got m=%0b c2=%0d s2=%0b c8=%0d exp m=1 c2=0 s2=0 c8=0", match2, cnt2, sat2, match_cnt_o);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic v, ld, ov, clr;
    logic [1:0] s;
    logic [5:0] p;
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 9) < 8);
      ld  = ($urandom_range(0, 39) == 0);
      ov  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 59) == 0);
      s   = 2'($urandom_range(0, 1));
      p   = {1'b0, 1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'($urandom)};
      step(v, s, ld, p, ov, clr);
      chk_cnt++;
      if (match_o !== exp_match || result_o !== 2'(exp_res()) || match_cnt_o !== 8'(c8) ||
          cnt2 !== 2'(c2) || sat2 !== (c2 == 3) || cnt_sat_o !== (c8 == 255))
        $display("FAIL random cyc=%0d got m=%0b r=%0d c=%0d c2=%0d exp m=%0b r=%0d c=%0d c2=%0d",
                 i, match_o, result_o, match_cnt_o, cnt2, exp_match, exp_res(), c8, c2);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 2'd0, 1'b1, 6'b10_00_01, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 6'd0, 1'b0, 1'b0);
    chk_cnt++; if (match_o !== 1'b1 || match_cnt_o === 8'd0) $display("FAIL pre_reset got m=%0b c=%0d exp m=1 c>0", match_o, match_cnt_o); else pass_cnt++;
    #2 rst_ni = 0;
    #1;
    chk_cnt++;
    if (result_o !== 2'd0 || match_o !== 1'b0 || match_cnt_o !== 8'd0 || cnt2 !== 2'd0 || cnt_sat_o !== 1'b0)
      $display("FAIL async_reset got r=%0d m=%0b c=%0d c2=%0d s=%0b exp all 0", result_o, match_o, match_cnt_o, cnt2, cnt_sat_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    rst_ni = 1;
    model_reset();
    step(1'b1, 2'd1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 6'd0, 1'b0, 1'b0);
    chk_cnt++;
    if (result_o !== 2'd0 || match_o !== 1'b0 || match_cnt_o !== 8'd0)
      $display("FAIL post_reset_unarmed got r=%0d m=%0b c=%0d exp r=0 m=0 c=0", result_o, match_o, match_cnt_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_no_load();
    test_basic();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_gap_and_load();
    test_saturate();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
